dmem_arbiter: RTL and testbench

//  Two-master arbiter for the single data memory port (addr / wdata / 4-bit byte-enable we / rdata).

---
 rtl/dmem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-master arbiter for the single data memory port. Master 0 is
//             the core load/store path, master 1 the debug/DMA loader. Every
//             transaction passes through one registered ACCESS cycle, so the
//             memory is only ever driven from latched request state.
//  Options  : ARB_FIXED_PRIO_EN - master 0 always wins a simultaneous request
//             (default build: round robin with strict alternation).
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  // master 0
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_we,
  output logic            m0_gnt,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_rdata,
  // master 1
  input  logic            m1_req,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_we,
  output logic            m1_gnt,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_rdata,
  // data memory
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_we,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q;
  logic            last_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   we_q;
  logic            ack0_q, ack1_q;
  logic [DW-1:0]   rdata0_q, rdata1_q;

  logic            w_win0, w_win1;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   wdata_d;
  logic [BW-1:0]   we_d;

  // Arbitration winner among the current requests (only used while IDLE).
`ifdef ARB_FIXED_PRIO_EN
  assign w_win0 = m0_req;
  assign w_win1 = m1_req & ~m0_req;
`else
  // The master that was not served last wins a tie.
  assign w_win0 = m0_req & (~m1_req | last_q);
  assign w_win1 = m1_req & (~m0_req | ~last_q);
`endif

  // Next-state and grant decode; grants are only possible while IDLE.
  always_comb begin
    state_d = state_q;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        m0_gnt = w_win0;
        m1_gnt = w_win1;
        if (w_win1) begin
          addr_d  = m1_addr;
          wdata_d = m1_wdata;
          we_d    = m1_we;
          state_d = ACCESS;
        end else if (w_win0) begin
          addr_d  = m0_addr;
          wdata_d = m0_wdata;
          we_d    = m0_we;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops out of ACCESS immediately so mem_we falls at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, ownership tracking, ack pulses and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      if (state_q == IDLE && (w_win0 || w_win1)) begin
        owner_q <= w_win1;
        last_q  <= w_win1;
      end
      if (state_q == ACCESS) begin
        ack0_q <= ~owner_q;
        ack1_q <= owner_q;
        // Writes leave the owner's previous read data untouched.
        if (we_q == '0) begin
          if (owner_q) begin
            rdata1_q <= mem_rdata;
          end else begin
            rdata0_q <= mem_rdata;
          end
        end
      end
    end
  end

  // Memory port is driven only during ACCESS and is zero otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (state_q == ACCESS) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_we    = we_q;
    end
  end

  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter. A transaction-level model
//             predicts grants, the memory port, acks and read data every
//             cycle; directed tests pin the model with literal expectations.
//             Define ARB_FIXED_PRIO_EN for both DUT and bench to exercise the
//             fixed-priority build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, byte-lane write on the clock edge.
  logic [31:0] tbmem [0:255];
  assign mem_rdata = tbmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) tbmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // acc_v : a transaction was accepted on the previous edge (memory busy now)
  // ack_v : a transaction finished on the previous edge (ack due now)
  logic        acc_v = 1'b0, ack_v = 1'b0;
  int          acc_o = 0, ack_o = 0, last_m = 1;
  logic [31:0] acc_a = '0, acc_wd = '0;
  logic [3:0]  acc_we = '0;
  logic [31:0] rexp [2];
  logic [31:0] refmem [0:255];

  always @(negedge clk) begin
    int win;
    if (!reset) begin
      chk("rst_m0_gnt", {31'b0, m0_gnt}, 0);
      chk("rst_m1_gnt", {31'b0, m1_gnt}, 0);
      chk("rst_m0_ack", {31'b0, m0_ack}, 0);
      chk("rst_m1_ack", {31'b0, m1_ack}, 0);
      chk("rst_mem_we", {28'b0, mem_we}, 0);
      chk("rst_m0_rdata", m0_rdata, 0);
      chk("rst_m1_rdata", m1_rdata, 0);
      acc_v = 1'b0; ack_v = 1'b0; last_m = 1;
      rexp[0] = '0; rexp[1] = '0;
    end else begin
      win = -1;
      if (!acc_v) begin
`ifdef ARB_FIXED_PRIO_EN
        if (m0_req) win = 0;
        else if (m1_req) win = 1;
`else
        if (m0_req && m1_req) win = (last_m == 0) ? 1 : 0;
        else if (m0_req) win = 0;
        else if (m1_req) win = 1;
`endif
      end
      chk("m_m0_gnt", {31'b0, m0_gnt}, (win == 0) ? 1 : 0);
      chk("m_m1_gnt", {31'b0, m1_gnt}, (win == 1) ? 1 : 0);
      chk("m_m0_ack", {31'b0, m0_ack}, (ack_v && ack_o == 0) ? 1 : 0);
      chk("m_m1_ack", {31'b0, m1_ack}, (ack_v && ack_o == 1) ? 1 : 0);
      chk("m_mem_addr", mem_addr, acc_v ? acc_a : 32'h0);
      chk("m_mem_wdata", mem_wdata, acc_v ? acc_wd : 32'h0);
      chk("m_mem_we", {28'b0, mem_we}, acc_v ? {28'b0, acc_we} : 32'h0);
      chk("m_m0_rdata", m0_rdata, rexp[0]);
      chk("m_m1_rdata", m1_rdata, rexp[1]);
      // advance across the coming clock edge
      ack_v = acc_v;
      ack_o = acc_o;
      if (acc_v) begin
        if (acc_we == 4'h0) rexp[acc_o] = refmem[acc_a[9:2]];
        else
          for (int b = 0; b < 4; b++)
            if (acc_we[b]) refmem[acc_a[9:2]][8*b +: 8] = acc_wd[8*b +: 8];
      end
      acc_v = (win >= 0);
      if (win >= 0) begin
        acc_o  = win;
        last_m = win;
        acc_a  = (win == 1) ? m1_addr  : m0_addr;
        acc_wd = (win == 1) ? m1_wdata : m0_wdata;
        acc_we = (win == 1) ? m1_we    : m0_we;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_txn(input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] we, output logic [31:0] rd, output int lat);
    bit found;
    int g;
    rd = '0; lat = -1;
    @(posedge clk); #1;
    if (m == 0) begin m0_addr = a; m0_wdata = wd; m0_we = we; m0_req = 1'b1; end
    else        begin m1_addr = a; m1_wdata = wd; m1_we = we; m1_req = 1'b1; end
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_gnt) || (m == 1 && m1_gnt)) begin found = 1; break; end
    end
    chk("txn_gnt_seen", {31'b0, found}, 1);
    g = cyc;
    @(posedge clk); #1;
    m0_req = (m == 0) ? 1'b0 : m0_req;
    m1_req = (m == 1) ? 1'b0 : m1_req;
    if (!found) return;
    found = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin found = 1; break; end
    end
    chk("txn_ack_seen", {31'b0, found}, 1);
    lat = cyc - g;
    rd = (m == 0) ? m0_rdata : m1_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, ng, prev, got;
    bit found;
    for (int i = 0; i < 256; i++) begin tbmem[i] = '0; refmem[i] = '0; end
    tbmem[8] = 32'h11223344; refmem[8] = 32'h11223344;
    rexp[0] = '0; rexp[1] = '0;

    // 1: reset, then idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t1_m0_gnt", {31'b0, m0_gnt}, 0);
    chk("t1_mem_we", {28'b0, mem_we}, 0);
    chk("t1_mem_addr", mem_addr, 0);
    chk("t1_m0_rdata", m0_rdata, 0);
    chk("t1_m1_rdata", m1_rdata, 0);

    // 2: m0 full write then read back
    do_txn(0, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
    chk("t2_wr_latency", lat, 2);
    do_txn(0, 32'h10, 32'h0, 4'h0, rd, lat);
    chk("t2_rd_latency", lat, 2);
    chk("t2_rd_data", rd, 32'hDEADBEEF);

    // 3: m1 single-lane write over preloaded word
    do_txn(1, 32'h20, 32'h00AA0000, 4'b0100, rd, lat);
    chk("t3_wr_keeps_rdata", rd, 32'h0);
    do_txn(1, 32'h20, 32'h0, 4'h0, rd, lat);
    chk("t3_rd_data", rd, 32'h11AA3344);
    chk("t3_m0_rdata_kept", m0_rdata, 32'hDEADBEEF);

    // 4 / 6: both masters requesting continuously
    @(posedge clk); #1;
    m0_addr = 32'h10; m0_we = 4'h0; m1_addr = 32'h20; m1_we = 4'h0;
    m0_req = 1'b1; m1_req = 1'b1;
    ng = 0; prev = -1;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin
        got = m1_gnt ? 1 : 0;
        chk("t6_fixed_winner", got, 0);
        prev = cyc;
        ng++;
      end
    end
    chk("t6_grant_count", ng, 4);
    @(posedge clk); #1 m0_req = 1'b0;
    found = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m1_gnt) begin found = 1; break; end
    end
    chk("t6_m1_gnt_seen", {31'b0, found}, 1);
    chk("t6_m1_gnt_gap", cyc - prev, 2);
    @(posedge clk); #1 m1_req = 1'b0;
`else
    for (int i = 0; i < 40 && ng < 8; i++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin
        got = m1_gnt ? 1 : 0;
        chk("t4_rr_order", got, ng % 2);
        if (prev >= 0) chk("t4_gnt_gap", cyc - prev, 2);
        prev = cyc;
        ng++;
      end
    end
    chk("t4_grant_count", ng, 8);
    @(posedge clk); #1 m0_req = 1'b0; m1_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("t4_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t4_m1_rdata", m1_rdata, 32'h11AA3344);

    // 5: reset during ACCESS of an m1 write
    @(posedge clk); #1;
    m1_addr = 32'h30; m1_wdata = 32'h55667788; m1_we = 4'hF; m1_req = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m1_gnt) begin found = 1; break; end
    end
    chk("t5_gnt_seen", {31'b0, found}, 1);
    @(posedge clk); #1 m1_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t5_mem_we_async", {28'b0, mem_we}, 0);
    chk("t5_mem_addr_async", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_m1_ack", {31'b0, m1_ack}, 0);
    end
    @(posedge clk); #1 m0_addr = 32'h10; m0_we = 4'h0; m0_req = 1'b1;
    @(negedge clk);
    chk("t5_idle_after_reset", {31'b0, m0_gnt}, 1);
    @(posedge clk); #1 m0_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_read_after_reset", m0_rdata, 32'hDEADBEEF);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
